if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer for the IF stage. It owns the program counter, issues one instruction-memory request at a time with a request/grant/response handshake, and arbitrates next-PC sources: EX branch, ID jump, or sequential PC+4. It squashes in-flight fetches on redirect and presents one buffered instruction (IF_Valid/IF_Instr/IF_PC) to the IF/ID register, honouring the pipeline stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_ADDR_WIDTH, 10, word-address width of instruction memory.

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
PC_Stall  input  1  downstream stall; IF output must hold
ID_Jump  input  1  jump redirect from ID
ID_PC_dest  input  32  jump target
EX_PC_Branch  input  1  taken-branch redirect from EX
EX_PC_Branch_dest  input  32  branch target
IMem_Req  output  1  fetch request
IMem_Addr  output  IMEM_ADDR_WIDTH  word address = PC_Out[IMEM_ADDR_WIDTH+1:2]
IMem_Gnt  input  1  request accepted this cycle
IMem_Rvalid  input  1  read data valid
IMem_Rdata  input  32  instruction word
PC_Out  output  32  PC of the next fetch to issue
IF_Valid  output  1  IF_Instr/IF_PC hold a valid instruction
IF_Instr  output  32  fetched instruction
IF_PC  output  32  PC of IF_Instr

Behaviour:
- Reset (any state, including mid-fetch): state=S_IDLE, PC_Out=RESET_PC, IMem_Req=0, IF_Valid=0, IF_Instr=32'h0000_0013 (NOP), IF_PC=0, kill flag=0. The memory shares Reset. IMem_Rvalid is ignored in S_IDLE.
- FSM states:
  - S_IDLE: one cycle after reset, then move to S_REQ.
  - S_REQ: IMem_Req=1 only when the output slot is free (IF_Valid==0 or PC_Stall==0). Otherwise IMem_Req=0 and the state holds. IMem_Req stays high until IMem_Gnt. On grant, Fetch_PC<=PC_Out, PC_Out<=PC_Out+4 (mod 2^32, wraps), and the state moves to S_WAIT.
  - S_WAIT: IMem_Req=0. On IMem_Rvalid:
    - kill=1: discard the data, clear kill, go to S_REQ.
    - kill=0: IF_Instr<=IMem_Rdata, IF_PC<=Fetch_PC, IF_Valid<=1, go to S_REQ.
- Minimum sequential throughput is one instruction per 2 cycles (grant cycle, response cycle) with zero-latency memory. Exactly one request is outstanding at any time.
- IF output slot: when PC_Stall=0 and no response is written, IF_Valid<=0 (consumed). When PC_Stall=1, IF_Valid, IF_Instr and IF_PC hold.
- Redirect priority: EX_PC_Branch > ID_Jump > sequential. The redirect target has bits[1:0] forced to 0. A redirect is honoured even when PC_Stall=1.
- On a redirect cycle:
  - PC_Out<=target and IF_Valid<=0 (flush).
  - In S_REQ with IMem_Gnt: go to S_WAIT with kill=1; Fetch_PC is don't-care; PC_Out=target (not +4).
  - In S_REQ without grant: stay in S_REQ; the next request uses the target.
  - In S_WAIT without IMem_Rvalid: kill<=1.
  - In S_WAIT with IMem_Rvalid: drop the response, go to S_REQ, kill=0.
  - In S_IDLE: PC_Out<=target.
- IMem_Addr is combinational from PC_Out.

Test Plan:
- Reset then sequential fetch, zero-latency memory (Gnt=1, Rvalid the cycle after grant) -> IMem_Addr 0,1,2; IF_PC 0x0,0x4,0x8 with IF_Valid pulsing every 2 cycles; PC_Out=0xC after third grant.
- PC_Stall=1 while IF_Valid=1 with IF_PC=0x4 -> IF_Valid, IF_PC, IF_Instr held; IMem_Req=0; after stall drops, next request addresses 0x8.
- EX_PC_Branch=1 with dest 0x100 in S_WAIT, Rvalid 2 cycles later -> that response is dropped (IF_Valid stays 0); next IMem_Addr=0x40; IF_PC=0x100.
- EX_PC_Branch (0x200) and ID_Jump (0x300) asserted the same cycle -> PC_Out=0x200; ID target ignored.
- ID_Jump dest 0x103 on the grant cycle -> kill set, granted response discarded, PC_Out=0x100, next IF_PC=0x100.
- PC_Out=0xFFFF_FFFC, grant -> PC_Out wraps to 0x0; Reset asserted in S_WAIT -> PC_Out=RESET_PC, IF_Valid=0, a stale Rvalid in S_IDLE produces no output.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_if
//   Instruction-memory request/grant/response bus used by the IF fetch
//   sequencer. One request is outstanding at a time; the response arrives
//   on IMem_Rvalid some cycles after the grant.
//
//   IMem_Req     fetch request (master -> slave)
//   IMem_Addr    word address of the fetch (master -> slave)
//   IMem_Gnt     request accepted this cycle (slave -> master)
//   IMem_Rvalid  read data valid (slave -> master)
//   IMem_Rdata   instruction word (slave -> master)
//
//   master : fetch sequencer side
//   slave  : instruction memory side
// ---------------------------------------------------------------------------
interface if_fetch_ctrl_if #(
  parameter int IMEM_ADDR_WIDTH = 10
) ();

  logic                       IMem_Req;
  logic [IMEM_ADDR_WIDTH-1:0] IMem_Addr;
  logic                       IMem_Gnt;
  logic                       IMem_Rvalid;
  logic [31:0]                IMem_Rdata;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Gnt,
    input  IMem_Rvalid,
    input  IMem_Rdata
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Gnt,
    output IMem_Rvalid,
    output IMem_Rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch sequencer for the IF stage. Owns the program counter,
//   issues one instruction-memory request at a time, selects the next PC
//   (EX branch > ID jump > PC+4), squashes in-flight fetches on redirect and
//   holds one buffered instruction for the IF/ID register.
//
//   Clk                system clock, rising edge
//   Reset              synchronous, active-high
//   PC_Stall           downstream stall; IF output slot must hold
//   ID_Jump/ID_PC_dest               jump redirect from ID
//   EX_PC_Branch/EX_PC_Branch_dest   taken-branch redirect from EX
//   imem               instruction-memory bus (master side)
//   PC_Out             PC of the next fetch to issue
//   IF_Valid/IF_Instr/IF_PC          buffered instruction for IF/ID
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  PC_Stall,
  input  logic                  ID_Jump,
  input  logic [31:0]           ID_PC_dest,
  input  logic                  EX_PC_Branch,
  input  logic [31:0]           EX_PC_Branch_dest,
  if_fetch_ctrl_if.master       imem,
  output logic [31:0]           PC_Out,
  output logic                  IF_Valid,
  output logic [31:0]           IF_Instr,
  output logic [31:0]           IF_PC
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        slot_free;
  logic        imem_req;
  logic        gnt_fire;

  always_comb begin
    redirect     = EX_PC_Branch | ID_Jump;
    redirect_tgt = EX_PC_Branch ? align_word(EX_PC_Branch_dest)
                                : align_word(ID_PC_dest);

    // A request may only go out if its response will have somewhere to land:
    // either the slot is empty or it is being consumed this cycle.
    slot_free = ~if_valid_q | ~PC_Stall;
    imem_req  = (state_q == S_REQ) & slot_free;
    gnt_fire  = imem_req & imem.IMem_Gnt;

    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    // Unstalled downstream consumes the slot unless refilled below.
    if_valid_d = if_valid_q & PC_Stall;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (gnt_fire) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_WAIT;
          // A fetch granted in a redirect cycle is on the wrong path.
          kill_d     = redirect;
        end
      end
      S_WAIT: begin
        if (imem.IMem_Rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect) begin
            if_valid_d = 1'b1;
            if_instr_d = imem.IMem_Rdata;
            if_pc_d    = fetch_pc_q;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides the sequential PC and flushes the slot, stall or not.
    if (redirect) begin
      pc_d       = redirect_tgt;
      if_valid_d = 1'b0;
    end
  end

  // Control and visible output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // PC of the outstanding fetch; only read when its response is accepted,
  // so it needs no reset.
  always_ff @(posedge Clk) begin
    fetch_pc_q <= fetch_pc_d;
  end

  assign imem.IMem_Req  = imem_req;
  assign imem.IMem_Addr = pc_q[IMEM_ADDR_WIDTH+1:2];

  assign PC_Out   = pc_q;
  assign IF_Valid = if_valid_q;
  assign IF_Instr = if_instr_q;
  assign IF_PC    = if_pc_q;

endmodule
